// File: rtl/syscall_print_ctrl.sv
// Print-string syscall sequencer: borrows idle data-memory cycles to walk a NUL-terminated
// string and emits one character per cycle on a registered strobe interface.
module syscall_print_ctrl #(
    parameter int unsigned MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_w,
    input  logic [31:0] a0,
    input  logic [31:0] cpu_a,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] mem_rd,
    output logic [31:0] mem_a,
    output logic        grant,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic        busy,
    output logic        done,
    output logic        truncated
);
    localparam int unsigned CountW = $clog2(MAX_LEN + 1);
    localparam logic [CountW-1:0] MaxCount = CountW'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StFetch, StEmit} state_e;

    state_e              state_q, state_d;
    logic [31:0]         pr_addr_q, pr_addr_d;
    logic [31:0]         word_buf_q, word_buf_d;
    logic [CountW-1:0]   count_q, count_d, count_inc;
    logic [7:0]          char_out_q, char_out_d;
    logic                char_valid_q, char_valid_d;
    logic                done_q, done_d;
    logic                truncated_q, truncated_d;
    logic [7:0]          lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pr_addr_q    <= '0;
            word_buf_q   <= '0;
            count_q      <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            done_q       <= 1'b0;
            truncated_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pr_addr_q    <= pr_addr_d;
            word_buf_q   <= word_buf_d;
            count_q      <= count_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            done_q       <= done_d;
            truncated_q  <= truncated_d;
        end
    end

    // Little-endian byte lane of the buffered word.
    always_comb begin
        lane = '0;
        unique case (pr_addr_q[1:0])
            2'd0: lane = word_buf_q[7:0];
            2'd1: lane = word_buf_q[15:8];
            2'd2: lane = word_buf_q[23:16];
            2'd3: lane = word_buf_q[31:24];
        endcase
    end

    // The CPU MEM stage always wins; the printer only takes otherwise idle cycles.
    assign grant     = (state_q == StFetch) && !(cpu_mem_read || cpu_mem_write);
    assign mem_a     = grant ? {pr_addr_q[31:2], 2'b00} : cpu_a;
    assign busy      = (state_q != StIdle);
    assign count_inc = count_q + CountW'(1);

    always_comb begin
        state_d      = state_q;
        pr_addr_d    = pr_addr_q;
        word_buf_d   = word_buf_q;
        count_d      = count_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        done_d       = 1'b0;
        truncated_d  = truncated_q;
        case (state_q)
            StIdle: begin
                if (syscall_w) begin
                    pr_addr_d   = a0;
                    count_d     = '0;
                    truncated_d = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (grant) begin
                    word_buf_d = mem_rd;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (lane == 8'h00) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    char_out_d   = lane;
                    char_valid_d = 1'b1;
                    pr_addr_d    = pr_addr_q + 32'd1;
                    count_d      = count_inc;
                    if (count_inc == MaxCount) begin
                        state_d     = StIdle;
                        done_d      = 1'b1;
                        truncated_d = 1'b1;
                    end else if (pr_addr_q[1:0] == 2'd3) begin
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign done       = done_q;
    assign truncated  = truncated_q;

endmodule

// File: tb/tb_syscall_print_ctrl.sv
// Self-checking bench: a per-cycle timeline of expected outputs is derived from the string
// contents and the CPU busy schedule, then compared against the DUT on every cycle.
module tb_syscall_print_ctrl;
    localparam int unsigned MaxLen = 4;
    localparam int NCyc = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall_w = 1'b0;
    logic [31:0] a0 = '0;
    logic [31:0] cpu_a = '0;
    logic        cpu_mem_read = 1'b0;
    logic        cpu_mem_write = 1'b0;
    logic [31:0] mem_rd;
    logic [31:0] mem_a;
    logic        grant, char_valid, busy, done, truncated;
    logic [7:0]  char_out;

    bit [31:0] mem [64];
    assign mem_rd = mem[mem_a[7:2]];

    // Stimulus schedule, indexed by cycle (cycle k = interval after rising edge k).
    bit        sys_s   [NCyc];
    bit [31:0] a0_s    [NCyc];
    bit        rd_s    [NCyc];
    bit        wr_s    [NCyc];
    bit [31:0] cpu_a_s [NCyc];

    // Expected outputs, indexed by cycle.
    bit        exp_valid [NCyc];
    bit [7:0]  exp_char  [NCyc];
    bit        exp_done  [NCyc];
    bit        exp_busy  [NCyc];
    bit        exp_grant [NCyc];
    bit [31:0] exp_maddr [NCyc];
    bit        exp_trunc [NCyc];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    syscall_print_ctrl #(.MAX_LEN(MaxLen)) dut (
        .clk           (clk),
        .reset         (reset),
        .syscall_w     (syscall_w),
        .a0            (a0),
        .cpu_a         (cpu_a),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .mem_rd        (mem_rd),
        .mem_a         (mem_a),
        .grant         (grant),
        .char_out      (char_out),
        .char_valid    (char_valid),
        .busy          (busy),
        .done          (done),
        .truncated     (truncated)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < NCyc) begin
            syscall_w     = sys_s[cyc];
            a0            = a0_s[cyc];
            cpu_mem_read  = rd_s[cyc];
            cpu_mem_write = wr_s[cyc];
            cpu_a         = cpu_a_s[cyc];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Timeline of one print requested in cycle req: each word needs one CPU-idle cycle
    // (first at or after the request edge), then one character per cycle from that word.
    function automatic int plan_print(input int req, input bit [31:0] addr);
        int n = req + 1;
        int c = n;
        int f, e, d;
        int cnt = 0;
        bit [31:0] p = addr;
        bit [31:0] w;
        bit [7:0]  b;
        bit [1:0]  ln;
        bit tr = 1'b0;
        bit fin = 1'b0;
        bit nxt;
        d = n + 2;
        sys_s[req] = 1'b1;
        a0_s[req]  = addr;
        while (!fin) begin
            f = c;
            while (f < NCyc - 8 && (rd_s[f] || wr_s[f])) f++;
            exp_grant[f] = 1'b1;
            exp_maddr[f] = {p[31:2], 2'b00};
            w   = mem[p[7:2]];
            e   = f + 2;
            nxt = 1'b0;
            while (!fin && !nxt) begin
                ln = p[1:0];
                b  = w[8*ln +: 8];
                if (b == 8'h00) begin
                    d = e; fin = 1'b1;
                end else begin
                    exp_valid[e] = 1'b1;
                    exp_char[e]  = b;
                    cnt++;
                    p = p + 32'd1;
                    if (cnt == int'(MaxLen)) begin
                        d = e; tr = 1'b1; fin = 1'b1;
                    end else if (ln == 2'd3) begin
                        c = e; nxt = 1'b1;
                    end else begin
                        e++;
                    end
                end
            end
        end
        for (int k = n; k < d; k++) exp_busy[k] = 1'b1;
        exp_done[d] = 1'b1;
        for (int k = n; k < NCyc; k++) exp_trunc[k] = (k >= d) ? tr : 1'b0;
        return d;
    endfunction

    task automatic compare_cycle();
        int k = cyc;
        if (k >= NCyc) return;
        if (done) done_seen++;
        check("char_valid", 32'(char_valid), 32'(exp_valid[k]));
        if (exp_valid[k]) check("char_out", 32'(char_out), 32'(exp_char[k]));
        check("done", 32'(done), 32'(exp_done[k]));
        check("busy", 32'(busy), 32'(exp_busy[k]));
        check("grant", 32'(grant), 32'(exp_grant[k]));
        check("truncated", 32'(truncated), 32'(exp_trunc[k]));
        check("mem_a", mem_a, exp_grant[k] ? exp_maddr[k] : cpu_a_s[k]);
    endtask

    task automatic run_until(input int last);
        while (cyc < last && cyc < NCyc - 1) begin
            @(negedge clk);
            compare_cycle();
        end
    endtask

    task automatic start_print(input bit [31:0] addr, output int req, output int d);
        req = cyc + 1;
        d   = plan_print(req, addr);
    endtask

    initial begin
        int req, d, n, seen0, c;
        bit [31:0] r, w;
        bit [7:0] bt;
        reset = 1'b1;
        for (int k = 0; k < NCyc; k++) cpu_a_s[k] = $urandom();
        repeat (3) @(negedge clk);
        check("rst_char_out", 32'(char_out), 32'h0);
        check("rst_char_valid", 32'(char_valid), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_truncated", 32'(truncated), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_mem_a", mem_a, cpu_a_s[cyc]);
        reset = 1'b0;
        run_until(cyc + 2);

        // "Hi"
        mem[0] = 32'h0000_6948;
        start_print(32'h0040_0000, req, d);
        n = req + 1;
        check("hi_model_done_at", 32'(d - req), 32'd5);
        run_until(n);
        check("hi_grant", 32'(grant), 32'd1);
        check("hi_mem_a", mem_a, 32'h0040_0000);
        run_until(n + 1);
        check("hi_grant_off", 32'(grant), 32'd0);
        run_until(n + 2);
        check("hi_char_h", {23'd0, char_valid, char_out}, 32'h148);
        run_until(n + 3);
        check("hi_char_i", {23'd0, char_valid, char_out}, 32'h169);
        run_until(n + 4);
        check("hi_done", {29'd0, done, truncated, busy}, 32'b100);
        run_until(cyc + 2);

        // Unaligned start crossing into the next word
        mem[0] = 32'h4100_0000;
        mem[1] = 32'h0000_0000;
        start_print(32'h0040_0003, req, d);
        n = req + 1;
        check("unal_model_done_at", 32'(d - req), 32'd5);
        run_until(n + 2);
        check("unal_char_a", {23'd0, char_valid, char_out}, 32'h141);
        check("unal_refetch_grant", 32'(grant), 32'd1);
        check("unal_refetch_addr", mem_a, 32'h0040_0004);
        run_until(n + 4);
        check("unal_done", 32'(done), 32'd1);
        run_until(cyc + 2);

        // CPU contention for three cycles from the first FETCH cycle
        mem[0] = 32'h0000_6948;
        req = cyc + 1;
        n   = req + 1;
        for (int k = n; k < n + 3; k++) begin
            rd_s[k]    = 1'b1;
            cpu_a_s[k] = 32'h1234_5678;
        end
        d = plan_print(req, 32'h0040_0000);
        check("cont_model_done_at", 32'(d - req), 32'd8);
        run_until(n);
        check("cont_grant", 32'(grant), 32'd0);
        check("cont_mem_a", mem_a, 32'h1234_5678);
        run_until(n + 3);
        check("cont_grant_late", 32'(grant), 32'd1);
        run_until(n + 5);
        check("cont_char_h", {23'd0, char_valid, char_out}, 32'h148);
        run_until(d + 2);

        // Request while busy is ignored
        mem[2] = 32'h0063_6261;
        seen0 = done_seen;
        start_print(32'h0040_0008, req, d);
        n = req + 1;
        sys_s[n + 2] = 1'b1;
        a0_s[n + 2]  = 32'h0040_0000;
        check("busyreq_model_done_at", 32'(d - req), 32'd6);
        run_until(d + 4);
        check("busyreq_done_count", 32'(done_seen - seen0), 32'd1);

        // Truncation at MaxLen
        mem[2] = 32'h4443_4241;
        mem[3] = 32'h0046_4544;
        start_print(32'h0040_0008, req, d);
        check("trunc_model_done_at", 32'(d - req), 32'd6);
        run_until(d);
        check("trunc_last", {21'd0, char_valid, done, truncated, char_out}, 32'h744);
        run_until(d + 2);
        check("trunc_sticky", 32'(truncated), 32'd1);
        mem[0] = 32'h0000_6948;
        start_print(32'h0040_0000, req, d);
        run_until(req + 1);
        check("trunc_cleared", 32'(truncated), 32'd0);
        run_until(d + 1);

        // Asynchronous reset in the middle of EMIT
        mem[0] = 32'h6463_6261;
        start_print(32'h0040_0000, req, d);
        n = req + 1;
        run_until(n + 3);
        reset = 1'b1;
        #1;
        check("arst_outputs", {21'd0, char_valid, done, truncated, busy, grant, char_out},
              32'h0);
        check("arst_mem_a", mem_a, cpu_a_s[cyc]);
        for (int k = cyc + 1; k < NCyc; k++) begin
            exp_valid[k] = 1'b0;
            exp_done[k]  = 1'b0;
            exp_busy[k]  = 1'b0;
            exp_grant[k] = 1'b0;
            exp_trunc[k] = 1'b0;
        end
        run_until(cyc + 2);
        reset = 1'b0;
        run_until(cyc + 8);

        // Randomized prints with random CPU traffic
        for (int k = 0; k < 64; k++) begin
            for (int j = 0; j < 4; j++) begin
                bt = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                w[8*j +: 8] = bt;
            end
            mem[k] = w;
        end
        for (int k = cyc + 1; k < NCyc; k++) begin
            rd_s[k] = ($urandom_range(0, 9) < 3);
            wr_s[k] = ($urandom_range(0, 19) == 0);
        end
        for (int t = 0; t < 200 && cyc < NCyc - 64; t++) begin
            req = cyc + 1 + int'($urandom_range(0, 2));
            r   = $urandom();
            if ($urandom_range(0, 9) == 0) r = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            d = plan_print(req, r);
            n = req + 1;
            if ($urandom_range(0, 1) == 1) begin
                c = n + int'($urandom_range(0, d - 1 - n));
                sys_s[c] = 1'b1;
                a0_s[c]  = $urandom();
            end
            run_until(d - 1);
        end
        run_until(cyc + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
